// File: rtl/i2c_bus_arbiter.sv
// Two-requester round-robin arbiter in front of an I2C master engine.
// Latches the winner's transaction fields, issues a start once the engine
// is free, waits for completion or a tick-based timeout, and returns
// done/err/rdata to the granted requester.
module i2c_bus_arbiter #(
    parameter logic [7:0] TIMEOUT_TICKS = 8'd200
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tick_in,
    input  logic [1:0] req,
    input  logic [6:0] dev_addr0,
    input  logic [6:0] dev_addr1,
    input  logic [7:0] reg_addr0,
    input  logic [7:0] reg_addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       rw0,
    input  logic       rw1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic [7:0] rdata,
    output logic       m_start,
    output logic       m_abort,
    output logic [6:0] m_dev_addr,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_wdata,
    output logic       m_rw,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_err,
    input  logic [7:0] m_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StComplete} state_e;

    state_e     state_q;
    logic [7:0] tmo_cnt_q;
    logic       last_q;   // requester served most recently
    logic       owner_q;  // requester owning the current transaction
    logic       winner;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_q;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    // Arbitration FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            tmo_cnt_q  <= 8'd0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            err        <= 2'b00;
            rdata      <= 8'h00;
            m_start    <= 1'b0;
            m_abort    <= 1'b0;
            m_dev_addr <= 7'h00;
            m_reg_addr <= 8'h00;
            m_wdata    <= 8'h00;
            m_rw       <= 1'b0;
        end else begin
            m_start <= 1'b0;
            m_abort <= 1'b0;
            done    <= 2'b00;
            err     <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        owner_q    <= winner;
                        gnt        <= winner ? 2'b10 : 2'b01;
                        m_dev_addr <= winner ? dev_addr1 : dev_addr0;
                        m_reg_addr <= winner ? reg_addr1 : reg_addr0;
                        m_wdata    <= winner ? wdata1 : wdata0;
                        m_rw       <= winner ? rw1 : rw0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (!m_busy) begin
                        m_start   <= 1'b1;
                        tmo_cnt_q <= 8'd0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Engine completion takes priority over a same-cycle timeout.
                    if (m_done) begin
                        rdata   <= m_rdata;
                        done    <= gnt;
                        err     <= m_ack_err ? gnt : 2'b00;
                        state_q <= StComplete;
                    end else if (tmo_cnt_q == TIMEOUT_TICKS) begin
                        m_abort <= 1'b1;
                        done    <= gnt;
                        err     <= gnt;
                        state_q <= StComplete;
                    end else if (tick_in) begin
                        // Reaching TIMEOUT_TICKS leaves WAIT, so the count never wraps.
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                StComplete: begin
                    gnt     <= 2'b00;
                    last_q  <= owner_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed testbench for i2c_bus_arbiter: a per-cycle vector table followed
// by hand-written contention, busy, timeout, coincidence and reset sequences.
module tb_i2c_bus_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       tick_in = 1'b0;
    logic [1:0] req = 2'b00;
    logic [6:0] dev_addr0 = 7'h68, dev_addr1 = 7'h2A;
    logic [7:0] reg_addr0 = 8'h00, reg_addr1 = 8'h10;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h5A;
    logic       rw0 = 1'b1, rw1 = 1'b0;
    logic [1:0] gnt, done, err;
    logic [7:0] rdata;
    logic       m_start, m_abort;
    logic [6:0] m_dev_addr;
    logic [7:0] m_reg_addr, m_wdata;
    logic       m_rw;
    logic       m_busy = 1'b0, m_done = 1'b0, m_ack_err = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    int passed = 0;
    int total = 0;
    bit onehot_bad = 1'b0;
    bit early = 1'b0;
    int starts;

    i2c_bus_arbiter #(.TIMEOUT_TICKS(8'd4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .req(req),
        .dev_addr0(dev_addr0), .dev_addr1(dev_addr1),
        .reg_addr0(reg_addr0), .reg_addr1(reg_addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rw0(rw0), .rw1(rw1),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .m_start(m_start), .m_abort(m_abort), .m_dev_addr(m_dev_addr),
        .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_rw(m_rw),
        .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_rdata(m_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       busy;
        logic       mdone;
        logic       ack;
        logic [7:0] mrd;
        logic [1:0] e_gnt;
        logic [1:0] e_done;
        logic [1:0] e_err;
        logic [7:0] e_rdata;
        logic       e_start;
        logic       e_abort;
        logic [6:0] e_dev;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    // One clock, sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
        if (gnt == 2'b11) onehot_bad = 1'b1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req = 2'b00; m_busy = 1'b0; m_done = 1'b0; tick_in = 1'b0;
        step();
        rst_in = 1'b0;
    endtask

    task automatic wait_grant_start(input logic [1:0] exp_gnt, input string tag);
        for (int i = 0; i < 30 && gnt == 2'b00; i++) step();
        check({tag, "_gnt"}, gnt, exp_gnt);
        for (int i = 0; i < 30 && !m_start; i++) step();
        check({tag, "_start"}, m_start, 1'b1);
    endtask

    task automatic run_txn(input logic [1:0] exp_gnt, input logic [7:0] rd, input logic ack,
                           input string tag);
        wait_grant_start(exp_gnt, tag);
        m_done = 1'b1; m_rdata = rd; m_ack_err = ack;
        step();
        m_done = 1'b0; m_ack_err = 1'b0;
        check({tag, "_done"}, {done, err, rdata}, {exp_gnt, (ack ? exp_gnt : 2'b00), rd});
        step();
    endtask

    // Four ticks spaced 8 cycles apart; flags any early abort or done.
    task automatic four_ticks();
        for (int k = 0; k < 4; k++) begin
            repeat (7) begin
                step();
                if (m_abort || done != 2'b00) early = 1'b1;
            end
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            if (m_abort || done != 2'b00) early = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        //          rst  req    bsy   mdn   ack   mrd    gnt    done   err    rdata  st    ab    dev
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 7'h00};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 7'h68};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 7'h68};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 7'h68};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h45, 2'b01, 2'b01, 2'b00, 8'h45, 1'b0, 1'b0, 7'h68};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h45, 1'b0, 1'b0, 7'h68};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h99, 2'b00, 2'b00, 2'b00, 8'h45, 1'b0, 1'b0, 7'h68};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b00, 8'h45, 1'b0, 1'b0, 7'h2A};
        vecs[8]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b00, 8'h45, 1'b0, 1'b0, 7'h2A};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b00, 8'h45, 1'b1, 1'b0, 7'h2A};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 8'h3C, 2'b10, 2'b10, 2'b10, 8'h3C, 1'b0, 1'b0, 7'h2A};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h3C, 1'b0, 1'b0, 7'h2A};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h3C, 1'b0, 1'b0, 7'h68};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h3C, 1'b1, 1'b0, 7'h68};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h12, 2'b01, 2'b01, 2'b00, 8'h12, 1'b0, 1'b0, 7'h68};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h12, 1'b0, 1'b0, 7'h68};

        for (int i = 0; i < 16; i++) begin
            rst_in = vecs[i].rst; req = vecs[i].req; m_busy = vecs[i].busy;
            m_done = vecs[i].mdone; m_ack_err = vecs[i].ack; m_rdata = vecs[i].mrd;
            step();
            check($sformatf("vec%0d", i),
                  {gnt, done, err, rdata, m_start, m_abort, m_dev_addr},
                  {vecs[i].e_gnt, vecs[i].e_done, vecs[i].e_err, vecs[i].e_rdata,
                   vecs[i].e_start, vecs[i].e_abort, vecs[i].e_dev});
        end
        m_done = 1'b0; m_ack_err = 1'b0;

        // Contention after reset: order 0,1,0 and never both grants.
        do_reset();
        onehot_bad = 1'b0;
        req = 2'b11;
        run_txn(2'b01, 8'h11, 1'b0, "rr0");
        run_txn(2'b10, 8'h22, 1'b1, "rr1");
        run_txn(2'b01, 8'h33, 1'b0, "rr2");
        check("rr_onehot", onehot_bad, 1'b0);

        // Busy master: start only in the first free cycle, exactly once.
        do_reset();
        req = 2'b01; m_busy = 1'b1;
        step();
        check("busy_gnt", gnt, 2'b01);
        starts = 0;
        repeat (10) begin
            step();
            if (m_start) starts++;
        end
        m_busy = 1'b0;
        step();
        check("busy_first_free", m_start, 1'b1);
        if (m_start) starts++;
        req = 2'b00;
        repeat (3) begin
            step();
            if (m_start) starts++;
        end
        check("busy_start_once", starts, 1);
        m_done = 1'b1; m_rdata = 8'hA5;
        step();
        m_done = 1'b0;
        check("busy_done", {done, err, rdata}, {2'b01, 2'b00, 8'hA5});
        step();

        // Timeout after the 4th tick: abort, err set, rdata kept at A5.
        req = 2'b01;
        wait_grant_start(2'b01, "tmo");
        req = 2'b00;
        early = 1'b0;
        four_ticks();
        check("tmo_no_early", early, 1'b0);
        step();
        check("tmo_abort", {m_abort, done, err, rdata}, {1'b1, 2'b01, 2'b01, 8'hA5});
        step();
        check("tmo_abort_pulse", {m_abort, done, gnt}, {1'b0, 2'b00, 2'b00});

        // m_done in the same cycle the counter hits the limit wins.
        req = 2'b01;
        wait_grant_start(2'b01, "coin");
        req = 2'b00;
        early = 1'b0;
        four_ticks();
        m_done = 1'b1; m_ack_err = 1'b0; m_rdata = 8'h77;
        step();
        m_done = 1'b0;
        check("coin_no_abort", {m_abort, done, err, rdata}, {1'b0, 2'b01, 2'b00, 8'h77});
        step();

        // Reset mid-WAIT clears everything and restores requester 0 priority.
        req = 2'b10;
        wait_grant_start(2'b10, "rstw");
        step();
        req = 2'b00;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("rstw_outputs",
              {gnt, done, err, rdata, m_start, m_abort, m_dev_addr, m_reg_addr, m_wdata, m_rw},
              48'h0);
        req = 2'b11;
        step();
        check("rstw_regrant", gnt, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 8'd200, the tick_in count after which an ungranted-done transaction aborts.
REQ-002 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_in  input  1  one-clk_in-cycle enable at I2C bit rate, from the divider.
REQ-005 SHALL have port req  input  2  per-requester transaction request, level, bit i = requester i.
REQ-006 SHALL have ports dev_addr0/dev_addr1  input  7, reg_addr0/reg_addr1  input  8, wdata0/wdata1  input  8, rw0/rw1  input  1 (1 = read); per-requester transaction fields.
REQ-007 SHALL have port gnt  output  2  one-hot grant, at most one bit high.
REQ-008 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  2  valid with done; 1 = NACK or timeout.
REQ-010 SHALL have port rdata  output  8  read data, valid with done, held until next completion.
REQ-011 SHALL have ports m_start  output  1, m_abort  output  1, m_dev_addr  output  7, m_reg_addr  output  8, m_wdata  output  8, m_rw  output  1; master engine command side.
REQ-012 SHALL have ports m_busy  input  1, m_done  input  1 (one-cycle pulse), m_ack_err  input  1 (valid with m_done), m_rdata  input  8 (valid with m_done); master engine status side.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, COMPLETE.
REQ-014 IDLE: if req != 0, SHALL select a winner, latch its dev_addr/reg_addr/wdata/rw into internal registers, set its gnt bit, and go to ISSUE.
REQ-015 Winner selection SHALL be round-robin: if both requests are high, grant the requester not served last; if one is high, grant it.
REQ-016 ISSUE: while m_busy=1, SHALL stay in ISSUE; when m_busy=0, SHALL pulse m_start for exactly one cycle and go to WAIT.
REQ-017 m_dev_addr/m_reg_addr/m_wdata/m_rw SHALL drive the latched registers continuously from grant until return to IDLE; they are unaffected by requester input changes after latching.
REQ-018 Latency SHALL be: req high in IDLE at cycle N -> gnt at N+1 -> m_start at N+2 when m_busy=0.
REQ-019 WAIT: the 8-bit timeout counter, cleared on entry, SHALL increment on each tick_in=1 cycle.
REQ-020 WAIT: on m_done=1, SHALL capture m_rdata into rdata, capture m_ack_err as the error flag, and go to COMPLETE.
REQ-021 WAIT: when the counter equals TIMEOUT_TICKS and m_done=0, SHALL pulse m_abort for one cycle, set the error flag, leave rdata unchanged, and go to COMPLETE.
REQ-022 When m_done and the timeout condition coincide in one cycle, m_done SHALL win; no m_abort.
REQ-023 COMPLETE: SHALL pulse done[g] and drive err[g] for one cycle, clear gnt, record g as last served, and return to IDLE.
REQ-024 Requester dropping req during ISSUE/WAIT SHALL NOT cancel the transaction; done still pulses.
REQ-025 req still high in IDLE after COMPLETE SHALL be treated as a new request, subject to round-robin.
REQ-026 m_done outside WAIT SHALL be ignored.
REQ-027 The timeout counter SHALL saturate at TIMEOUT_TICKS and never wrap.

Reset
REQ-028 rst_in=1 SHALL force IDLE, gnt=0, done=0, err=0, rdata=8'h00, m_start=0, m_abort=0, m_* fields=0, counter=0, and last served=1, so requester 0 wins first; this applies in any state, mid-transaction included.
REQ-029 Reset SHALL NOT generate m_abort; the master engine is reset by the same rst_in.

Verification
REQ-030 Single read: req=2'b01, dev_addr0=7'h68, reg_addr0=8'h00, rw0=1; master returns m_rdata=8'h45, m_ack_err=0 -> gnt=01 at N+1, m_start at N+2 with m_dev_addr=68, done[0]=1, err[0]=0, rdata=45.
REQ-031 Contention: req=2'b11 held for three transactions after reset -> grant order 0,1,0; gnt never 2'b11.
REQ-032 Busy master: m_busy=1 for 10 cycles after grant -> m_start is asserted exactly once, in the first cycle m_busy=0.
REQ-033 Timeout: TIMEOUT_TICKS=4, no m_done, tick_in every 8 cycles -> m_abort pulse after the 4th tick, done=1 with err=1, rdata unchanged.
REQ-034 Coincident events: m_done on the same cycle the counter reaches TIMEOUT_TICKS -> no m_abort, err=m_ack_err.
REQ-035 Reset mid-WAIT: rst_in for 1 cycle -> all outputs 0 next cycle; a later req=2'b11 grants requester 0.
